// File: rtl/fetch_sequencer_if.sv
// -----------------------------------------------------------------------------
// fetch_sequencer_if
// Groups the instruction-memory read port and the downstream instruction
// issue/redirect port of the fetch sequencer.
//
//   imem_req       sequencer -> memory     read request
//   imem_addr      sequencer -> memory     read address (32 bit)
//   imem_ack       memory    -> sequencer  read data valid this cycle
//   imem_rdata     memory    -> sequencer  read data (32 bit)
//   instr_valid    sequencer -> consumer   fetched instruction available
//   instr          sequencer -> consumer   fetched instruction word
//   instr_pc       sequencer -> consumer   address instr came from
//   instr_ready    consumer  -> sequencer  consumer accepts instr
//   redirect_valid consumer  -> sequencer  accepted instr changes flow
//   redirect_sel   consumer  -> sequencer  PC mode for the redirect
//
// master: the fetch sequencer side. slave: memory + downstream side.
// -----------------------------------------------------------------------------
interface fetch_sequencer_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        instr_valid;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic        instr_ready;
  logic        redirect_valid;
  logic [1:0]  redirect_sel;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_ack,
    input  imem_rdata,
    output instr_valid,
    output instr,
    output instr_pc,
    input  instr_ready,
    input  redirect_valid,
    input  redirect_sel
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_ack,
    output imem_rdata,
    input  instr_valid,
    input  instr,
    input  instr_pc,
    output instr_ready,
    output redirect_valid,
    output redirect_sel
  );
endinterface

// File: rtl/fetch_sequencer.sv
// -----------------------------------------------------------------------------
// fetch_sequencer
// Sequences one instruction at a time: request the word at pc, hold it for
// the downstream consumer until accepted, then pulse the program counter
// enable with the selected PC mode and fetch again. A fetch that is not
// acknowledged within MAX_WAIT cycles halts the sequencer with a sticky fault.
//
// Parameters
//   MAX_WAIT  FETCH cycles without imem_ack before fault (2..255)
// Ports
//   clk       rising-edge clock
//   rst       synchronous active-high reset
//   pc        current PC from the program counter
//   bus       fetch_sequencer_if.master (imem read port + issue port)
//   pc_en     one-cycle program counter enable
//   pc_sel    PC mode to program counter (00 NORMAL,01 BEQ,10 JMP,11 BNE)
//   fault     sticky fetch-timeout flag
//   retired   count of accepted instructions (wraps modulo 2^32)
// -----------------------------------------------------------------------------
module fetch_sequencer #(
  parameter int unsigned MAX_WAIT = 32'd16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [31:0]             pc,
  fetch_sequencer_if.master       bus,
  output logic                    pc_en,
  output logic [1:0]              pc_sel,
  output logic                    fault,
  output logic [31:0]             retired
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_FETCH   = 3'd1,
    S_ISSUE   = 3'd2,
    S_ADVANCE = 3'd3,
    S_HALT    = 3'd4
  } state_t;

  // Last wait-counter value before a missing ack becomes a timeout.
  localparam logic [7:0] WAIT_LAST = 8'(MAX_WAIT - 32'd1);

  state_t      state_q,    state_d;
  logic [7:0]  wait_q,     wait_d;
  logic        fault_q,    fault_d;
  logic [31:0] retired_q,  retired_d;
  logic [31:0] instr_q,    instr_d;
  logic [31:0] instr_pc_q, instr_pc_d;
  logic [1:0]  sel_q,      sel_d;

  logic        imem_req_s;
  logic        instr_valid_s;
  logic        pc_en_s;
  logic [1:0]  pc_sel_s;

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      wait_q     <= 8'd0;
      fault_q    <= 1'b0;
      retired_q  <= 32'd0;
      instr_q    <= 32'd0;
      instr_pc_q <= 32'd0;
      sel_q      <= 2'b00;
    end else begin
      state_q    <= state_d;
      wait_q     <= wait_d;
      fault_q    <= fault_d;
      retired_q  <= retired_d;
      instr_q    <= instr_d;
      instr_pc_q <= instr_pc_d;
      sel_q      <= sel_d;
    end
  end

  // Next-state and datapath update logic.
  always_comb begin
    state_d    = state_q;
    wait_d     = wait_q;
    fault_d    = fault_q;
    retired_d  = retired_q;
    instr_d    = instr_q;
    instr_pc_d = instr_pc_q;
    sel_d      = sel_q;
    case (state_q)
      S_IDLE: begin
        state_d = S_FETCH;
      end
      S_FETCH: begin
        // An ack wins over the timeout even in the last allowed cycle.
        if (bus.imem_ack) begin
          instr_d    = bus.imem_rdata;
          instr_pc_d = pc;
          wait_d     = 8'd0;
          state_d    = S_ISSUE;
        end else if (wait_q == WAIT_LAST) begin
          fault_d = 1'b1;
          state_d = S_HALT;
        end else begin
          wait_d = wait_q + 8'd1;
        end
      end
      S_ISSUE: begin
        // Redirect inputs only mean something on the accepting cycle.
        if (bus.instr_ready) begin
          sel_d     = bus.redirect_valid ? bus.redirect_sel : 2'b00;
          retired_d = retired_q + 32'd1;
          state_d   = S_ADVANCE;
        end else begin
          state_d = S_ISSUE;
        end
      end
      S_ADVANCE: begin
        state_d = S_FETCH;
      end
      S_HALT: begin
        state_d = S_HALT;
        fault_d = 1'b1;
      end
      default: begin
        // Unreachable encoding: treat as a fault and park.
        fault_d = 1'b1;
        state_d = S_HALT;
      end
    endcase
  end

  // Control outputs decoded from the registered state.
  always_comb begin
    imem_req_s    = 1'b0;
    instr_valid_s = 1'b0;
    pc_en_s       = 1'b0;
    pc_sel_s      = 2'b00;
    case (state_q)
      S_IDLE: begin
        imem_req_s = 1'b0;
      end
      S_FETCH: begin
        imem_req_s = 1'b1;
      end
      S_ISSUE: begin
        instr_valid_s = 1'b1;
      end
      S_ADVANCE: begin
        pc_en_s  = 1'b1;
        pc_sel_s = sel_q;
      end
      S_HALT: begin
        imem_req_s = 1'b0;
      end
      default: begin
        imem_req_s = 1'b0;
      end
    endcase
  end

  assign bus.imem_req    = imem_req_s;
  assign bus.imem_addr   = pc;
  assign bus.instr_valid = instr_valid_s;
  assign bus.instr       = instr_q;
  assign bus.instr_pc    = instr_pc_q;
  assign pc_en           = pc_en_s;
  assign pc_sel          = pc_sel_s;
  assign fault           = fault_q;
  assign retired         = retired_q;

endmodule

// File: tb/tb_fetch_sequencer.sv
module tb_fetch_sequencer;

  localparam int MAXW = 16;

  // Abstract phases of the reference model.
  localparam int P_IDLE  = 0;
  localparam int P_FETCH = 1;
  localparam int P_ISSUE = 2;
  localparam int P_ADV   = 3;
  localparam int P_HALT  = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] pc;
  logic        pc_en;
  logic [1:0]  pc_sel;
  logic        fault;
  logic [31:0] retired;

  fetch_sequencer_if bus ();

  fetch_sequencer #(.MAX_WAIT(MAXW)) dut (
    .clk     (clk),
    .rst     (rst),
    .pc      (pc),
    .bus     (bus),
    .pc_en   (pc_en),
    .pc_sel  (pc_sel),
    .fault   (fault),
    .retired (retired)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  logic chk_en = 1'b0;
  logic preload = 1'b0;

  // Reference model state.
  int          m_phase;
  int          m_waited;
  logic        m_fault;
  logic [31:0] m_retired;
  logic [31:0] m_instr;
  logic [31:0] m_ipc;
  logic [1:0]  m_sel;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: one update per clock from the sampled inputs.
  always @(posedge clk) begin
    if (rst) begin
      m_phase   <= P_IDLE;
      m_waited  <= 0;
      m_fault   <= 1'b0;
      m_retired <= 32'd0;
      m_instr   <= 32'd0;
      m_ipc     <= 32'd0;
      m_sel     <= 2'b00;
    end else if (preload) begin
      m_retired <= 32'hFFFF_FFFF;
    end else if (m_phase == P_IDLE) begin
      m_phase <= P_FETCH;
    end else if (m_phase == P_FETCH) begin
      if (bus.imem_ack) begin
        m_instr  <= bus.imem_rdata;
        m_ipc    <= pc;
        m_waited <= 0;
        m_phase  <= P_ISSUE;
      end else if (m_waited + 1 >= MAXW) begin
        m_fault <= 1'b1;
        m_phase <= P_HALT;
      end else begin
        m_waited <= m_waited + 1;
      end
    end else if (m_phase == P_ISSUE) begin
      if (bus.instr_ready) begin
        m_sel     <= bus.redirect_valid ? bus.redirect_sel : 2'b00;
        m_retired <= m_retired + 32'd1;
        m_phase   <= P_ADV;
      end
    end else if (m_phase == P_ADV) begin
      m_phase <= P_FETCH;
    end
  end

  // Every-cycle comparison of DUT outputs against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      check("imem_req",    {31'd0, bus.imem_req},    {31'd0, (m_phase == P_FETCH)});
      if (m_phase == P_FETCH) check("imem_addr", bus.imem_addr, pc);
      check("instr_valid", {31'd0, bus.instr_valid}, {31'd0, (m_phase == P_ISSUE)});
      check("instr",       bus.instr,    m_instr);
      check("instr_pc",    bus.instr_pc, m_ipc);
      check("pc_en",       {31'd0, pc_en}, {31'd0, (m_phase == P_ADV)});
      check("pc_sel",      {30'd0, pc_sel}, {30'd0, (m_phase == P_ADV) ? m_sel : 2'b00});
      check("fault",       {31'd0, fault}, {31'd0, m_fault});
      check("retired",     retired, m_retired);
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1;
    pc = 32'd0;
    bus.imem_ack = 1'b0;
    bus.imem_rdata = 32'd0;
    bus.instr_ready = 1'b0;
    bus.redirect_valid = 1'b0;
    bus.redirect_sel = 2'b00;
    cyc();
    cyc();
    chk_en = 1'b1;
    rst = 1'b0;
    // IDLE after reset
    @(negedge clk);
    check("idle_req",   {31'd0, bus.imem_req},    32'd0);
    check("idle_valid", {31'd0, bus.instr_valid}, 32'd0);
    check("idle_pc_en", {31'd0, pc_en},           32'd0);
    check("idle_ret",   retired,                  32'd0);
    check("idle_instr", bus.instr,                32'd0);
    cyc(); // FETCH, ack in first cycle
    pc = 32'd0; bus.imem_ack = 1'b1; bus.imem_rdata = 32'h1234_5678; bus.instr_ready = 1'b1;
    @(negedge clk);
    check("t1_req", {31'd0, bus.imem_req}, 32'd1);
    cyc(); // ISSUE
    bus.imem_ack = 1'b0; bus.imem_rdata = 32'd0;
    @(negedge clk);
    check("t1_valid", {31'd0, bus.instr_valid}, 32'd1);
    check("t1_instr", bus.instr, 32'h1234_5678);
    check("t1_ipc",   bus.instr_pc, 32'd0);
    cyc(); // ADVANCE
    bus.instr_ready = 1'b0;
    @(negedge clk);
    check("t1_pc_en",  {31'd0, pc_en}, 32'd1);
    check("t1_pc_sel", {30'd0, pc_sel}, 32'd0);
    check("t1_ret",    retired, 32'd1);
    cyc(); // FETCH, redirect pulsed here must be ignored
    pc = 32'd4; bus.redirect_valid = 1'b1; bus.redirect_sel = 2'b10;
    @(negedge clk);
    check("t2_addr", bus.imem_addr, 32'd4);
    cyc(); // still FETCH, ack now
    bus.redirect_valid = 1'b0; bus.redirect_sel = 2'b00;
    bus.imem_ack = 1'b1; bus.imem_rdata = 32'hA5A5_0001;
    cyc(); // ISSUE
    bus.imem_ack = 1'b0; bus.instr_ready = 1'b1;
    cyc(); // ADVANCE
    bus.instr_ready = 1'b0;
    @(negedge clk);
    check("t2_pc_sel", {30'd0, pc_sel}, 32'd0);
    check("t2_ret",    retired, 32'd2);
    cyc(); // FETCH
    pc = 32'd8; bus.imem_ack = 1'b1; bus.imem_rdata = 32'hB0B0_0002;
    cyc(); // ISSUE, handshake with JMP redirect
    bus.imem_ack = 1'b0; bus.instr_ready = 1'b1;
    bus.redirect_valid = 1'b1; bus.redirect_sel = 2'b10;
    cyc(); // ADVANCE, redirect here must be ignored
    bus.instr_ready = 1'b0; bus.redirect_sel = 2'b01;
    @(negedge clk);
    check("t3_pc_en",  {31'd0, pc_en}, 32'd1);
    check("t3_pc_sel", {30'd0, pc_sel}, 32'd2);
    check("t3_ret",    retired, 32'd3);
    cyc(); // FETCH
    bus.redirect_valid = 1'b0; bus.redirect_sel = 2'b00;
    pc = 32'h0000_000C; bus.imem_ack = 1'b1; bus.imem_rdata = 32'hC0DE_0003;
    cyc(); // ISSUE, stall with noise on ack/redirect/pc
    bus.imem_ack = 1'b1; bus.imem_rdata = 32'hDEAD_BEEF;
    bus.redirect_valid = 1'b1; bus.redirect_sel = 2'b11; pc = 32'h0000_0100;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("stall_valid", {31'd0, bus.instr_valid}, 32'd1);
      check("stall_instr", bus.instr, 32'hC0DE_0003);
      check("stall_ipc",   bus.instr_pc, 32'h0000_000C);
      check("stall_pc_en", {31'd0, pc_en}, 32'd0);
      check("stall_ret",   retired, 32'd3);
      cyc();
    end
    // Preload the retired counter to its maximum while stalled.
    @(negedge clk);
    #1;
    force dut.retired_q = 32'hFFFF_FFFF;
    preload = 1'b1;
    cyc();
    release dut.retired_q;
    preload = 1'b0;
    @(negedge clk);
    check("pre_ret", retired, 32'hFFFF_FFFF);
    bus.imem_ack = 1'b0; bus.instr_ready = 1'b1;
    cyc(); // ADVANCE, counter wraps
    bus.instr_ready = 1'b0; bus.redirect_valid = 1'b0; bus.redirect_sel = 2'b00;
    @(negedge clk);
    check("wrap_ret",    retired, 32'd0);
    check("wrap_pc_sel", {30'd0, pc_sel}, 32'd3);
    check("wrap_fault",  {31'd0, fault}, 32'd0);
    cyc(); // FETCH: reset together with ack
    pc = 32'h0000_0010; bus.imem_ack = 1'b1; bus.imem_rdata = 32'h5555_AAAA; rst = 1'b1;
    cyc(); // IDLE
    rst = 1'b0; bus.imem_ack = 1'b0;
    @(negedge clk);
    check("rstack_valid", {31'd0, bus.instr_valid}, 32'd0);
    check("rstack_instr", bus.instr, 32'd0);
    check("rstack_req",   {31'd0, bus.imem_req}, 32'd0);
    cyc(); // FETCH cycle 1
    @(negedge clk);
    check("rstack_fetch", {31'd0, bus.imem_req}, 32'd1);
    check("rstack_valid2", {31'd0, bus.instr_valid}, 32'd0);
    // Ack in the last allowed FETCH cycle beats the timeout.
    for (int i = 0; i < MAXW - 1; i++) cyc();
    bus.imem_ack = 1'b1; bus.imem_rdata = 32'h0000_0016;
    cyc(); // ISSUE
    bus.imem_ack = 1'b0;
    @(negedge clk);
    check("last_ack_valid", {31'd0, bus.instr_valid}, 32'd1);
    check("last_ack_fault", {31'd0, fault}, 32'd0);
    check("last_ack_instr", bus.instr, 32'h0000_0016);
    bus.instr_ready = 1'b1;
    cyc(); // ADVANCE
    bus.instr_ready = 1'b0;
    cyc(); // FETCH cycle 1, no ack ever
    for (int i = 0; i < MAXW; i++) begin
      @(negedge clk);
      check("to_nofault", {31'd0, fault}, 32'd0);
      check("to_req",     {31'd0, bus.imem_req}, 32'd1);
      cyc();
    end
    @(negedge clk);
    check("to_fault", {31'd0, fault}, 32'd1);
    check("to_req0",  {31'd0, bus.imem_req}, 32'd0);
    bus.imem_ack = 1'b1; bus.instr_ready = 1'b1; bus.redirect_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cyc();
      @(negedge clk);
      check("halt_fault", {31'd0, fault}, 32'd1);
      check("halt_valid", {31'd0, bus.instr_valid}, 32'd0);
      check("halt_pc_en", {31'd0, pc_en}, 32'd0);
    end
    rst = 1'b1;
    cyc(); // IDLE
    rst = 1'b0; bus.imem_ack = 1'b0; bus.instr_ready = 1'b0; bus.redirect_valid = 1'b0;
    @(negedge clk);
    check("clr_fault", {31'd0, fault}, 32'd0);
    check("clr_req",   {31'd0, bus.imem_req}, 32'd0);
    cyc(); // FETCH
    @(negedge clk);
    check("clr_fetch", {31'd0, bus.imem_req}, 32'd1);
    cyc();
    chk_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/fetch_sequencer.md
FETCH_SEQUENCER -- requirements
Module: fetch_sequencer

Interface
REQ-001 Parameter: MAX_WAIT, 16, cycles in FETCH without imem_ack before fault; legal range 2..255.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 pc  input  32  current PC from program counter pc_out.
REQ-005 imem_req  output  1  instruction memory read request.
REQ-006 imem_addr  output  32  read address.
REQ-007 imem_ack  input  1  read data valid this cycle.
REQ-008 imem_rdata  input  32  read data.
REQ-009 instr_valid  output  1  fetched instruction available downstream.
REQ-010 instr  output  32  fetched instruction word.
REQ-011 instr_pc  output  32  address instr was fetched from.
REQ-012 instr_ready  input  1  downstream accepts instr.
REQ-013 redirect_valid  input  1  accepted instruction changes control flow.
REQ-014 redirect_sel  input  2  PC mode for redirect: 00 NORMAL, 01 BEQ, 10 JMP, 11 BNE.
REQ-015 pc_en  output  1  clock enable to program counter.
REQ-016 pc_sel  output  2  PC mode to program counter.
REQ-017 fault  output  1  sticky fetch-timeout flag.
REQ-018 retired  output  32  count of accepted instructions.

Function
REQ-019 FSM states SHALL be IDLE, FETCH, ISSUE, ADVANCE, HALT; encoding is free.
REQ-020 IDLE SHALL go to FETCH unconditionally on the next cycle.
REQ-021 In FETCH, imem_req SHALL be 1 and imem_addr SHALL equal pc combinationally; imem_req SHALL be 0 in all other states.
REQ-022 imem_ack in FETCH, including the first FETCH cycle, SHALL capture imem_rdata into instr and pc into instr_pc, clear the wait counter, and enter ISSUE.
REQ-023 imem_ack outside FETCH SHALL be ignored.
REQ-024 Wait counter SHALL increment once per FETCH cycle without ack.
REQ-025 A FETCH cycle without ack in which the wait counter equals MAX_WAIT-1 SHALL enter HALT and set fault; an ack in that same cycle takes priority (goes to ISSUE, no fault).
REQ-026 In ISSUE, instr_valid SHALL be 1; instr and instr_pc SHALL be held stable until instr_ready=1.
REQ-027 On instr_valid and instr_ready: sample redirect_valid/redirect_sel (sel captured as redirect_sel if valid, else 00), increment retired modulo 2^32, enter ADVANCE.
REQ-028 redirect_valid SHALL be ignored in any cycle without an ISSUE handshake.
REQ-029 In ADVANCE, pc_en SHALL be 1 for exactly one cycle with pc_sel = captured sel; the next state SHALL be FETCH.
REQ-030 pc_en SHALL be 0 and pc_sel SHALL be 00 in all states except ADVANCE.
REQ-031 Latency: imem_ack cycle N -> instr_valid cycle N+1; handshake cycle M -> pc_en cycle M+1 -> imem_req with updated pc cycle M+2.
REQ-032 Minimum instruction period SHALL be 3 cycles (ack in first FETCH cycle, instr_ready=1 in ISSUE).
REQ-033 HALT SHALL be terminal: all request/enable outputs 0, fault=1, exit only via rst.
REQ-034 retired SHALL wrap from 0xFFFFFFFF to 0x00000000 without affecting other state.

Reset
REQ-035 When rst=1 at a clock edge: state IDLE, wait counter 0, fault 0, retired 0, instr 0, instr_pc 0, captured sel 00.
REQ-036 rst SHALL override all other inputs, including mid-FETCH with a pending ack (data discarded) and in HALT.
REQ-037 While in IDLE after reset, imem_req, instr_valid and pc_en SHALL all be 0.

Verification
REQ-038 Reset, pc=0, ack in first FETCH cycle with rdata=0x12345678, instr_ready=1 -> instr_valid 1 cycle later with instr=0x12345678, instr_pc=0; pc_en=1, pc_sel=00 next cycle; retired=1.
REQ-039 Handshake with redirect_valid=1, redirect_sel=10 -> ADVANCE cycle drives pc_en=1, pc_sel=10; redirect_valid=1 pulsed during FETCH only -> pc_sel=00.
REQ-040 instr_ready held 0 for 5 cycles in ISSUE -> instr_valid, instr, instr_pc stable for 5 cycles, pc_en=0, retired unchanged.
REQ-041 MAX_WAIT=16, no ack -> fault=1 and HALT after the 16th FETCH cycle; late ack ignored; rst -> fault=0, IDLE.
REQ-042 Preload retired=0xFFFFFFFF via 2^32 handshakes or a forced state, then one handshake -> retired=0x00000000.
REQ-043 rst asserted in the same cycle as imem_ack -> no ISSUE; IDLE then FETCH with instr_valid=0.
